// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, ALU op
// classes, FSM state encoding, mux select encodings and the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_SUB   = 3'b001;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef enum logic [2:0] {OPC_R, OPC_I, OPC_MEM, OPC_BR, OPC_J, OPC_BAD} op_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
  } ctl_t;

  // Opcode is zero-extended by the caller so any OPCODE_WIDTH compares exactly.
  function automatic op_class_e op_class(input logic [31:0] op);
    op_class_e c;
    c = OPC_BAD;
    if (op == 32'(OP_R)) c = OPC_R;
    else if (op == 32'(OP_ADDI) || op == 32'(OP_ORI) || op == 32'(OP_LUI)) c = OPC_I;
    else if (op == 32'(OP_LW) || op == 32'(OP_SW)) c = OPC_MEM;
    else if (op == 32'(OP_BEQ) || op == 32'(OP_BNE)) c = OPC_BR;
    else if (op == 32'(OP_J)) c = OPC_J;
    return c;
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface mips_ctrl_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int ALU_OP_WIDTH = 3,
  parameter int STATE_WIDTH  = 4
);
  logic [OPCODE_WIDTH-1:0] opcode_i;
  logic                    zero_i;
  logic                    mem_ready_i;
  logic                    pc_write_o;
  logic                    pc_write_eq_o;
  logic                    pc_write_ne_o;
  logic                    i_or_d_o;
  logic                    mem_read_o;
  logic                    mem_write_o;
  logic                    ir_write_o;
  logic                    mem_to_reg_o;
  logic                    reg_dst_o;
  logic                    reg_write_o;
  logic                    alu_src_a_o;
  logic [1:0]              alu_src_b_o;
  logic [1:0]              pc_source_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic                    illegal_opcode_o;
  logic [STATE_WIDTH-1:0]  state_o;

  modport master (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, pc_write_eq_o, pc_write_ne_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o, illegal_opcode_o,
           state_o
  );

  modport slave (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, pc_write_eq_o, pc_write_ne_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o, illegal_opcode_o,
           state_o
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control word decoder. Everything is forced to the
// idle word (ALU ADD, no enables) while reset is asserted.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic        reset_i,
  input  logic        mem_ready_i,
  input  logic        dec_bad_i,
  input  logic [31:0] opc_q_i,
  output ctl_t        ctl_o
);

  always_comb begin
    ctl_o        = '0;
    ctl_o.alu_op = ALU_ADD;
    if (!reset_i) begin
      case (state_i)
        S_FETCH: begin
          ctl_o.mem_read  = 1'b1;
          ctl_o.alu_src_b = SRCB_FOUR;
          ctl_o.pc_write  = mem_ready_i;
          ctl_o.ir_write  = mem_ready_i;
        end
        S_DECODE: begin
          ctl_o.alu_src_b = SRCB_IMM_SH2;
          ctl_o.illegal   = dec_bad_i;
        end
        S_EXEC_R: begin
          ctl_o.alu_src_a = 1'b1;
          ctl_o.alu_src_b = SRCB_RT;
          ctl_o.alu_op    = ALU_RTYPE;
        end
        S_WB_R: begin
          ctl_o.reg_dst   = 1'b1;
          ctl_o.reg_write = 1'b1;
        end
        S_EXEC_I: begin
          ctl_o.alu_src_a = 1'b1;
          ctl_o.alu_src_b = SRCB_IMM;
          if (opc_q_i == 32'(OP_ORI))      ctl_o.alu_op = ALU_ORI;
          else if (opc_q_i == 32'(OP_LUI)) ctl_o.alu_op = ALU_LUI;
        end
        S_WB_I:     ctl_o.reg_write = 1'b1;
        S_MEM_ADDR: begin
          ctl_o.alu_src_a = 1'b1;
          ctl_o.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          ctl_o.mem_read = 1'b1;
          ctl_o.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          ctl_o.mem_to_reg = 1'b1;
          ctl_o.reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          ctl_o.mem_write = 1'b1;
          ctl_o.i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          ctl_o.alu_src_a   = 1'b1;
          ctl_o.alu_op      = ALU_SUB;
          ctl_o.pc_source   = PCSRC_ALUOUT;
          ctl_o.pc_write_eq = (opc_q_i == 32'(OP_BEQ));
          ctl_o.pc_write_ne = (opc_q_i == 32'(OP_BNE));
        end
        S_JUMP: begin
          ctl_o.pc_write  = 1'b1;
          ctl_o.pc_source = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with opcode latch. Optional retired-instruction
// counter enabled by defining MIPS_PERF_COUNT_EN.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int ALU_OP_WIDTH = 3,
  parameter int STATE_WIDTH  = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  mips_ctrl_if.master bus
`ifdef MIPS_PERF_COUNT_EN
  , output logic [31:0] retired_o
`endif
);

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opc_q;
  op_class_e               dec_cls;
  ctl_t                    ctl;
  logic                    unused_zero;

  // Branch resolution happens in the datapath; the flag is not needed here.
  assign unused_zero = bus.zero_i;
  assign dec_cls     = op_class(32'(bus.opcode_i));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opc_q <= bus.opcode_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (bus.mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (dec_cls)
          OPC_R:   state_d = S_EXEC_R;
          OPC_I:   state_d = S_EXEC_I;
          OPC_MEM: state_d = S_MEM_ADDR;
          OPC_BR:  state_d = S_BRANCH;
          OPC_J:   state_d = S_JUMP;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (32'(opc_q) == 32'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready_i) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .reset_i     (reset_i),
    .mem_ready_i (bus.mem_ready_i),
    .dec_bad_i   (dec_cls == OPC_BAD),
    .opc_q_i     (32'(opc_q)),
    .ctl_o       (ctl)
  );

  assign bus.pc_write_o       = ctl.pc_write;
  assign bus.pc_write_eq_o    = ctl.pc_write_eq;
  assign bus.pc_write_ne_o    = ctl.pc_write_ne;
  assign bus.i_or_d_o         = ctl.i_or_d;
  assign bus.mem_read_o       = ctl.mem_read;
  assign bus.mem_write_o      = ctl.mem_write;
  assign bus.ir_write_o       = ctl.ir_write;
  assign bus.mem_to_reg_o     = ctl.mem_to_reg;
  assign bus.reg_dst_o        = ctl.reg_dst;
  assign bus.reg_write_o      = ctl.reg_write;
  assign bus.alu_src_a_o      = ctl.alu_src_a;
  assign bus.alu_src_b_o      = ctl.alu_src_b;
  assign bus.pc_source_o      = ctl.pc_source;
  assign bus.alu_op_o         = ALU_OP_WIDTH'(ctl.alu_op);
  assign bus.illegal_opcode_o = ctl.illegal;
  assign bus.state_o          = STATE_WIDTH'(state_q);

`ifdef MIPS_PERF_COUNT_EN
  logic [31:0] retired_q;
  logic        retire;

  // Only completing states count; DECODE->FETCH (illegal opcode) does not.
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_WB_R, S_WB_I, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP});

  always_ff @(posedge clk_i) begin
    if (reset_i)     retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign retired_o = retired_q;
`endif

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Next-generation MIPS control unit: a registered FSM sequencing each instruction over multiple cycles through a shared memory and a shared ALU. It sits between the instruction register opcode field and the multicycle datapath muxes and enables. It covers R-type, ADDI, ORI, LUI, LW, SW, BEQ, BNE and J. Memory accesses stall on a ready handshake.

Parameters:
OPCODE_WIDTH, 6, width of opcode_i
ALU_OP_WIDTH, 3, width of alu_op_o; must be >= 3
STATE_WIDTH, 4, width of state_o; must be >= 4

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  reset, synchronous, active-high
opcode_i  in  OPCODE_WIDTH  opcode from instruction register; sampled only in DECODE
zero_i  in  1  ALU zero flag; not used internally, branch gating is done in the datapath
mem_ready_i  in  1  memory completed the access this cycle
pc_write_o  out  1  unconditional PC load
pc_write_eq_o  out  1  PC load if zero
pc_write_ne_o  out  1  PC load if not zero
i_or_d_o  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
ir_write_o  out  1  instruction register load
mem_to_reg_o  out  1  write-back source: 1 = MDR, 0 = ALUOut
reg_dst_o  out  1  destination register: 1 = rd, 0 = rt
reg_write_o  out  1  register file write
alu_src_a_o  out  1  ALU A: 0 = PC, 1 = rs
alu_src_b_o  out  2  ALU B: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
pc_source_o  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
alu_op_o  out  ALU_OP_WIDTH  ALU operation class
illegal_opcode_o  out  1  one-cycle pulse when an unsupported opcode is decoded
state_o  out  STATE_WIDTH  current state, for debug

Behaviour:
- Reset: synchronous, active-high. Next edge with reset_i=1 forces state to FETCH. While reset_i=1, every write/enable/request output is 0 (pc_write*, mem_*, ir_write, reg_write). Mux selects are 0 and alu_op_o = ADD. Reset mid-instruction abandons the instruction; no partial write is issued after the reset edge.
- Outputs are decoded combinationally from the state. mem_ready_i qualifies only pc_write_o and ir_write_o in FETCH.
- FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=ADD, pc_source=00. pc_write_o = ir_write_o = mem_ready_i. Stay in FETCH until mem_ready_i=1, then go to DECODE.
- DECODE: src_a=0, src_b=11, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - R -> EXEC_R
  - ADDI/ORI/LUI -> EXEC_I
  - LW/SW -> MEM_ADDR
  - BEQ/BNE -> BRANCH
  - J -> JUMP
  - any other opcode -> FETCH with illegal_opcode_o=1 for this cycle only (instruction treated as NOP).
- EXEC_R: src_a=1, src_b=00, alu_op=R_TYPE; then WB_R.
- WB_R: reg_dst=1, reg_write=1, mem_to_reg=0; then FETCH.
- EXEC_I: src_a=1, src_b=10, alu_op = ADDI / ORI / LUI code chosen by the opcode latched in DECODE; then WB_I.
- WB_I: reg_dst=0, reg_write=1, mem_to_reg=0; then FETCH.
- MEM_ADDR: src_a=1, src_b=10, alu_op=ADD; then MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready_i, then MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready_i, then FETCH. mem_write_o stays high through the whole stall.
- BRANCH: src_a=1, src_b=00, alu_op=SUB, pc_source=01. pc_write_eq=1 for BEQ, pc_write_ne=1 for BNE; then FETCH.
- JUMP: pc_write=1, pc_source=10; then FETCH.
- The opcode is latched into an internal register in DECODE; later states use the latched copy, so opcode_i may change after DECODE.
- Latency with zero-wait memory (mem_ready_i tied 1): R/I = 4 cycles, LW = 5, SW = 4, BEQ/BNE/J = 3, illegal = 2. Each memory wait cycle adds 1.
- ALU op codes: ADD=100, ORI=101, LUI=110, R_TYPE=111, SUB=001. Codes are zero-extended when ALU_OP_WIDTH > 3.

Optional Feature:
MIPS_PERF_COUNT_EN:
- Defined: adds output retired_o (32 bits), reset to 0. Increments by 1 on each transition into FETCH from WB_R, WB_I, MEM_WB, MEM_WR, BRANCH or JUMP. Illegal opcodes are not counted. Wraps at 2^32-1 -> 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants: R=00, J=02, BEQ=04, BNE=05, ADDI=08, ORI=0D, LUI=0F, LW=23, SW=2B
  - ALU op constants
  - state encoding localparams: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, EXEC_I=4, WB_I=5, MEM_ADDR=6, MEM_RD=7, MEM_WB=8, MEM_WR=9, BRANCH=10, JUMP=11
  - alu_src_b and pc_source encodings
- One natural sub-module: mips_ctrl_decode, a combinational state-to-output decoder. The FSM and opcode latch stay in the top.

Test Plan:
- Reset held 3 cycles with opcode_i=23: all enables 0, state_o=0. First cycle after release: mem_read_o=1, i_or_d_o=0.
- mem_ready_i=1, opcode 00: states 0,1,2,3,0; reg_write_o=1 and reg_dst_o=1 only in state 3; alu_op_o=111 in state 2.
- LW (23) with mem_ready_i low 2 cycles in MEM_RD: mem_read_o and i_or_d_o held 3 cycles; total 7 cycles; reg_write_o=1 with mem_to_reg_o=1 in MEM_WB.
- BNE (05): 3 cycles; pc_write_ne_o=1 and pc_write_eq_o=0 in BRANCH with alu_op_o=001, pc_source_o=01.
- Opcode 3F: illegal_opcode_o pulses exactly 1 cycle in DECODE, next state FETCH, no reg_write/mem_write; with MIPS_PERF_COUNT_EN, retired_o unchanged.
- Reset asserted during MEM_WR stall: next cycle mem_write_o=0, state FETCH; retired_o=0.
